// File: rtl/bounce_generator.sv
// Switch-bounce stimulus source: on command, steps noisysignal to a new level with
// LFSR-jittered (or fixed) glitches back to the old level, then settles and pulses done.
module bounce_generator #(
   parameter logic        INIT_LEVEL    = 1'b0,
   parameter int unsigned BOUNCE_COUNT  = 4,
   parameter int unsigned GLITCH_MAX    = 4,
   parameter logic        JITTER_EN     = 1'b1,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter logic [7:0]  SEED          = 8'hA5
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic target,
   output logic noisysignal,
   output logic busy,
   output logic done
);

   localparam int unsigned SEG_W    = $clog2(GLITCH_MAX + 1);
   localparam int unsigned SET_W    = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned IDX_W    = (BOUNCE_COUNT > 0) ? $clog2(2 * BOUNCE_COUNT) : 1;
   localparam int unsigned LAST_IDX = (BOUNCE_COUNT > 0) ? 2 * BOUNCE_COUNT - 1 : 0;

   typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

   state_t           state, state_nx;
   logic [7:0]       lfsr;
   logic [IDX_W-1:0] seg_idx, seg_idx_nx;
   logic [SEG_W-1:0] seg_cnt, seg_cnt_nx;
   logic [SET_W-1:0] settle_cnt, settle_cnt_nx;
   logic             tgt, tgt_nx;
   logic             ns_nx, busy_nx, done_nx;
   logic [SEG_W-1:0] seg_len_c;

   // Length of a segment loaded at this edge, taken from the current LFSR value
   always_comb begin
      if (JITTER_EN)
         seg_len_c = SEG_W'(lfsr & 8'(GLITCH_MAX - 1)) + SEG_W'(1);
      else
         seg_len_c = SEG_W'(GLITCH_MAX);
   end

   always_comb begin
      state_nx      = state;
      seg_idx_nx    = seg_idx;
      seg_cnt_nx    = seg_cnt;
      settle_cnt_nx = settle_cnt;
      tgt_nx        = tgt;
      ns_nx         = noisysignal;
      busy_nx       = busy;
      done_nx       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (target != noisysignal) begin
                  ns_nx      = target;
                  tgt_nx     = target;
                  busy_nx    = 1'b1;
                  seg_idx_nx = '0;
                  seg_cnt_nx = seg_len_c;
                  if (BOUNCE_COUNT == 0) begin
                     state_nx      = SETTLE;
                     settle_cnt_nx = SET_W'(SETTLE_CYCLES);
                  end else begin
                     state_nx = BOUNCE;
                  end
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         BOUNCE: begin
            if (seg_cnt > SEG_W'(1)) begin
               seg_cnt_nx = seg_cnt - SEG_W'(1);
            end else if (seg_idx == IDX_W'(LAST_IDX)) begin
               ns_nx         = tgt;
               state_nx      = SETTLE;
               settle_cnt_nx = SET_W'(SETTLE_CYCLES);
            end else begin
               // Alternating segments: each expiry flips between new and old level
               seg_idx_nx = seg_idx + IDX_W'(1);
               seg_cnt_nx = seg_len_c;
               ns_nx      = ~noisysignal;
            end
         end
         SETTLE: begin
            if (settle_cnt > SET_W'(1)) begin
               settle_cnt_nx = settle_cnt - SET_W'(1);
            end else begin
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         lfsr        <= SEED;
         seg_idx     <= '0;
         seg_cnt     <= '0;
         settle_cnt  <= '0;
         tgt         <= INIT_LEVEL;
         noisysignal <= INIT_LEVEL;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         seg_idx     <= seg_idx_nx;
         seg_cnt     <= seg_cnt_nx;
         settle_cnt  <= settle_cnt_nx;
         tgt         <= tgt_nx;
         noisysignal <= ns_nx;
         busy        <= busy_nx;
         done        <= done_nx;
      end
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: three configurations driven by shared stimulus and
// checked every cycle against a waveform-queue model, plus hand-computed waveforms.
module tb_bounce_generator;

   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          reset, start, target;
   logic [NI-1:0] ns, busy, done;

   always #5 clk = ~clk;

   // fixed-length bounce, jittered bounce, clean step starting high
   bounce_generator #(.INIT_LEVEL(1'b0), .BOUNCE_COUNT(2), .GLITCH_MAX(2), .JITTER_EN(1'b0),
                      .SETTLE_CYCLES(8), .SEED(8'hA5)) u_fix (
      .clk(clk), .reset(reset), .start(start), .target(target),
      .noisysignal(ns[0]), .busy(busy[0]), .done(done[0]));
   bounce_generator #(.INIT_LEVEL(1'b0), .BOUNCE_COUNT(4), .GLITCH_MAX(4), .JITTER_EN(1'b1),
                      .SETTLE_CYCLES(8), .SEED(8'hA5)) u_jit (
      .clk(clk), .reset(reset), .start(start), .target(target),
      .noisysignal(ns[1]), .busy(busy[1]), .done(done[1]));
   bounce_generator #(.INIT_LEVEL(1'b1), .BOUNCE_COUNT(0), .GLITCH_MAX(1), .JITTER_EN(1'b0),
                      .SETTLE_CYCLES(3), .SEED(8'h3C)) u_clean (
      .clk(clk), .reset(reset), .start(start), .target(target),
      .noisysignal(ns[2]), .busy(busy[2]), .done(done[2]));

   int         cb [NI]  = '{2, 4, 0};
   int         cg [NI]  = '{2, 4, 1};
   int         cj [NI]  = '{0, 1, 0};
   int         cs [NI]  = '{8, 8, 3};
   logic       ci [NI]  = '{1'b0, 1'b0, 1'b1};
   logic [7:0] cse [NI] = '{8'hA5, 8'hA5, 8'h3C};

   typedef struct packed {
      logic ns;
      logic busy;
      logic done;
   } exp_t;

   exp_t       wave [NI][64];
   int         wlen [NI];
   int         wpos [NI];
   exp_t       cur  [NI];
   logic       m_lvl [NI];
   logic [7:0] m_lfsr [NI];
   bit         armed = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0b want %0b at %0t", nm, got, want, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Whole expected waveform of one accepted change, cycle 0 = cycle after the start edge
   task automatic build(input int i, input logic tgt);
      logic [7:0] l;
      int n, len;
      l = m_lfsr[i];
      n = 0;
      for (int s = 0; s < 2 * cb[i]; s++) begin
         len = (cj[i] != 0) ? 1 + (int'(l) & (cg[i] - 1)) : cg[i];
         for (int c = 0; c < len; c++) begin
            wave[i][n].ns   = (s % 2 == 0) ? tgt : ~tgt;
            wave[i][n].busy = 1'b1;
            wave[i][n].done = 1'b0;
            n++;
            l = lfsr_step(l);
         end
      end
      for (int c = 0; c < cs[i]; c++) begin
         wave[i][n].ns   = tgt;
         wave[i][n].busy = 1'b1;
         wave[i][n].done = 1'b0;
         n++;
      end
      wave[i][n].ns   = tgt;
      wave[i][n].busy = 1'b0;
      wave[i][n].done = 1'b1;
      n++;
      wlen[i] = n;
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
         if (reset) begin
            m_lvl[i]    = ci[i];
            m_lfsr[i]   = cse[i];
            wpos[i]     = 0;
            wlen[i]     = 0;
            cur[i].ns   = ci[i];
            cur[i].busy = 1'b0;
            cur[i].done = 1'b0;
            armed       = 1'b1;
         end else begin
            if (wpos[i] < wlen[i]) begin
               cur[i] = wave[i][wpos[i]];
               wpos[i]++;
            end else if (start && target != m_lvl[i]) begin
               build(i, target);
               cur[i]   = wave[i][0];
               wpos[i]  = 1;
               m_lvl[i] = target;
            end else begin
               cur[i].ns   = m_lvl[i];
               cur[i].busy = 1'b0;
               cur[i].done = start;
            end
            m_lfsr[i] = lfsr_step(m_lfsr[i]);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (armed) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d noisysignal", i), ns[i], cur[i].ns);
            chk($sformatf("u%0d busy", i), busy[i], cur[i].busy);
            chk($sformatf("u%0d done", i), done[i], cur[i].done);
         end
      end
   end

   logic [0:16] p_rise = 17'b11001100111111111;
   logic [0:16] p_fall = 17'b00110011000000000;
   logic [0:16] p_busy = 17'b11111111111111110;
   logic [0:16] p_done = 17'b00000000000000001;
   logic [0:6]  p_jit  = 7'b1100100;

   initial begin
      reset = 1'b1; start = 1'b0; target = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset ns fix", ns[0], 1'b0);
      chk("reset ns clean", ns[2], 1'b1);
      chk("reset busy fix", busy[0], 1'b0);
      chk("reset done fix", done[0], 1'b0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("idle ns fix", ns[0], 1'b0);
      chk("idle busy fix", busy[0], 1'b0);
      chk("idle done fix", done[0], 1'b0);

      // rising step; a start mid-sequence is ignored, a start on the done cycle is taken
      start = 1'b1; target = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("rise ns c%0d", k), ns[0], p_rise[k]);
         chk($sformatf("rise busy c%0d", k), busy[0], p_busy[k]);
         chk($sformatf("rise done c%0d", k), done[0], p_done[k]);
         if (k == 0) start = 1'b0;
         if (k == 5) begin start = 1'b1; target = 1'b0; end
         if (k == 6) start = 1'b0;
         if (k == 16) begin start = 1'b1; target = 1'b0; end
      end
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("fall ns c%0d", k), ns[0], p_fall[k]);
         chk($sformatf("fall busy c%0d", k), busy[0], p_busy[k]);
         chk($sformatf("fall done c%0d", k), done[0], p_done[k]);
         if (k == 0) start = 1'b0;
      end

      // no-op request: same level as already driven
      start = 1'b1; target = 1'b0;
      @(negedge clk);
      chk("noop done", done[0], 1'b1);
      chk("noop ns", ns[0], 1'b0);
      chk("noop busy", busy[0], 1'b0);
      start = 1'b0;
      @(negedge clk);
      chk("noop done drop", done[0], 1'b0);

      // reset in the middle of a sequence, then a fresh start right after reset
      start = 1'b1; target = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (k == 5) reset = 1'b1;
      end
      chk("abort ns", ns[0], 1'b0);
      chk("abort busy", busy[0], 1'b0);
      chk("abort done", done[0], 1'b0);
      reset = 1'b0; start = 1'b1; target = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("jitter ns c%0d", k), ns[1], p_jit[k]);
         chk($sformatf("jitter busy c%0d", k), busy[1], 1'b1);
         if (k == 0) start = 1'b0;
      end

      repeat (600) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         target = 1'($urandom_range(0, 1));
         reset  = ($urandom_range(0, 99) == 0);
      end
      reset = 1'b0; start = 1'b0;
      repeat (60) @(negedge clk);
      for (int i = 0; i < NI; i++) chk($sformatf("final busy u%0d", i), busy[i], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
